// File: rtl/branch_ctrl.sv
// branch_ctrl: 6502-style branch / JMP resolver with cycle-accurate latency.
// Ports: clk, rst (sync, active-high); start + opcode/jmp_ind/flags/pc_in/
//   operand request; mem_req/mem_addr/mem_ack/mem_data pointer read port;
//   busy, done, pc_load, pc_out, err result.
// Option: define JMP_IND_PAGE_BUG_EN for the NMOS page-wrap pointer fetch.
module branch_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  opcode,
   input  logic        jmp_ind,
   input  logic        flag_c,
   input  logic        flag_z,
   input  logic        flag_n,
   input  logic        flag_v,
   input  logic [15:0] pc_in,
   input  logic [15:0] operand,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data,
   output logic        busy,
   output logic        done,
   output logic        pc_load,
   output logic [15:0] pc_out,
   output logic        err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES);

   localparam logic [7:0] OP_BCC = 8'h04;
   localparam logic [7:0] OP_BCS = 8'h05;
   localparam logic [7:0] OP_BEQ = 8'h06;
   localparam logic [7:0] OP_BMI = 8'h07;
   localparam logic [7:0] OP_BNE = 8'h08;
   localparam logic [7:0] OP_BPL = 8'h09;
   localparam logic [7:0] OP_BVC = 8'h0A;
   localparam logic [7:0] OP_BVS = 8'h0B;
   localparam logic [7:0] OP_JMP = 8'h1C;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EVAL,
      S_ADD,
      S_FIX,
      S_IND_LO,
      S_IND_HI,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [7:0]    op_q;
   logic          ind_q;
   logic          c_q, z_q, n_q, v_q;
   logic [15:0]   pc_q;
   logic [15:0]   opnd_q;
   logic [7:0]    lo_q, lo_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [15:0]   pc_out_q, pc_out_d;
   logic          load_q, load_d;
   logic          err_q, err_d;

   logic          is_br, is_jmp, taken;
   logic          go_ind, go_abs, br_take, br_skip;
   logic [15:0]   br_off, br_tgt, hi_addr;
   logic          page_x;

   // Opcode class decode on the latched request
   assign is_br  = (op_q >= OP_BCC) && (op_q <= OP_BVS);
   assign is_jmp = (op_q == OP_JMP);

   always_comb begin
      taken = 1'b0;
      case (op_q)
         OP_BCC:  taken = ~c_q;
         OP_BCS:  taken =  c_q;
         OP_BEQ:  taken =  z_q;
         OP_BMI:  taken =  n_q;
         OP_BNE:  taken = ~z_q;
         OP_BPL:  taken = ~n_q;
         OP_BVC:  taken = ~v_q;
         OP_BVS:  taken =  v_q;
         default: taken = 1'b0;
      endcase
   end

   // Mutually exclusive so the EVAL decoder can be a unique case
   assign go_ind  = is_jmp &  ind_q;
   assign go_abs  = is_jmp & ~ind_q;
   assign br_take = is_br  &  taken;
   assign br_skip = is_br  & ~taken;

   assign br_off = {{8{opnd_q[7]}}, opnd_q[7:0]};
   assign br_tgt = pc_q + br_off;
   assign page_x = (br_tgt[15:8] != pc_q[15:8]);

`ifdef JMP_IND_PAGE_BUG_EN
   // NMOS quirk: pointer high byte never carries into the page
   assign hi_addr = {opnd_q[15:8], opnd_q[7:0] + 8'd1};
`else
   assign hi_addr = opnd_q + 16'd1;
`endif

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      pc_out_d = pc_out_q;
      load_d   = 1'b0;
      err_d    = 1'b0;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_EVAL;
         end
         S_EVAL: begin
            unique case (1'b1)
               go_ind: begin
                  state_d = S_IND_LO;
                  cnt_d   = '0;
               end
               go_abs: begin
                  state_d  = S_DONE;
                  pc_out_d = opnd_q;
                  load_d   = 1'b1;
               end
               br_take: begin
                  state_d = S_ADD;
               end
               br_skip: begin
                  state_d  = S_DONE;
                  pc_out_d = pc_q;
               end
               default: begin
                  state_d  = S_DONE;
                  pc_out_d = pc_q;
                  err_d    = 1'b1;
               end
            endcase
         end
         S_ADD: begin
            pc_out_d = br_tgt;
            if (page_x) begin
               state_d = S_FIX;
            end else begin
               state_d = S_DONE;
               load_d  = 1'b1;
            end
         end
         S_FIX: begin
            // pc_out_q already holds the target
            state_d = S_DONE;
            load_d  = 1'b1;
         end
         S_IND_LO: begin
            if (mem_ack) begin
               lo_d    = mem_data;
               cnt_d   = '0;
               state_d = S_IND_HI;
            end else if (cnt_inc == T_MAX) begin
               state_d  = S_DONE;
               pc_out_d = pc_q;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_IND_HI: begin
            if (mem_ack) begin
               state_d  = S_DONE;
               pc_out_d = {mem_data, lo_q};
               load_d   = 1'b1;
            end else if (cnt_inc == T_MAX) begin
               state_d  = S_DONE;
               pc_out_d = pc_q;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         ind_q    <= 1'b0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         pc_q     <= '0;
         opnd_q   <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         pc_out_q <= '0;
         load_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         pc_out_q <= pc_out_d;
         load_q   <= load_d;
         err_q    <= err_d;
         if (state_q == S_IDLE && start) begin
            op_q   <= opcode;
            ind_q  <= jmp_ind;
            c_q    <= flag_c;
            z_q    <= flag_z;
            n_q    <= flag_n;
            v_q    <= flag_v;
            pc_q   <= pc_in;
            opnd_q <= operand;
         end
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign pc_load = done & load_q;
   assign err     = done & err_q;
   assign pc_out  = pc_out_q;
   assign mem_req = (state_q == S_IND_LO) || (state_q == S_IND_HI);

   always_comb begin
      mem_addr = '0;
      if (state_q == S_IND_LO) mem_addr = opnd_q;
      if (state_q == S_IND_HI) mem_addr = hi_addr;
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed table, hand sequences and random ops
// checked against a rule-level reference model.
module tb_branch_ctrl;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst, start, jmp_ind;
   logic [7:0]  opcode;
   logic        flag_c, flag_z, flag_n, flag_v;
   logic [15:0] pc_in, operand;
   logic        mem_req, mem_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        busy, done, pc_load, err;
   logic [15:0] pc_out;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem [0:65535];
   int ack_delay  = 0;
   int ack_budget = 0;
   int acks_given = 0;
   int wcnt       = 0;

   typedef struct {
      logic [7:0]  op;
      logic        ind;
      logic [3:0]  f;
      logic [15:0] pc;
      logic [15:0] opnd;
      int          d;
      int          acks;
      int          lat;
      logic [15:0] epc;
      logic        eld;
      logic        eerr;
      logic        chk_pc;
   } vec_t;

   vec_t tbl [15];

   branch_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode),
      .jmp_ind(jmp_ind), .flag_c(flag_c), .flag_z(flag_z),
      .flag_n(flag_n), .flag_v(flag_v), .pc_in(pc_in),
      .operand(operand), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_data(mem_data), .busy(busy),
      .done(done), .pc_load(pc_load), .pc_out(pc_out), .err(err)
   );

   always #5 clk = ~clk;

   // Memory responder: acks after ack_delay waiting cycles,
   // at most ack_budget times per operation.
   always @(negedge clk) begin
      mem_ack = 1'b0;
      if (!busy) acks_given = 0;
      if (mem_req && acks_given < ack_budget) begin
         if (wcnt >= ack_delay) begin
            mem_ack  = 1'b1;
            mem_data = mem[mem_addr];
            wcnt     = 0;
            acks_given++;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] hi_of(input logic [15:0] a);
      int x;
`ifdef JMP_IND_PAGE_BUG_EN
      x = (int'(a) & 'hFF00) | ((int'(a) + 1) & 'h00FF);
`else
      x = (int'(a) + 1) & 'hFFFF;
`endif
      return x[15:0];
   endfunction

   function automatic vec_t mk(
      input logic [7:0] op, input logic ind, input logic [3:0] f,
      input logic [15:0] pc, input logic [15:0] opnd,
      input int d, input int acks, input int lat,
      input logic [15:0] epc, input logic eld, input logic eerr,
      input logic chk_pc);
      vec_t v;
      v.op = op; v.ind = ind; v.f = f; v.pc = pc; v.opnd = opnd;
      v.d = d; v.acks = acks; v.lat = lat; v.epc = epc;
      v.eld = eld; v.eerr = eerr; v.chk_pc = chk_pc;
      return v;
   endfunction

   // Reference: expected result straight from the opcode rules
   function automatic vec_t model(input vec_t v);
      vec_t r;
      bit c, z, n, vf, tk;
      int off, tgt, ha;
      r = v;
      {c, z, n, vf} = v.f;
      r.lat = 2; r.epc = v.pc; r.eld = 0; r.eerr = 0; r.chk_pc = 1;
      if (v.op >= 8'h04 && v.op <= 8'h0B) begin
         case (v.op)
            8'h04:   tk = !c;
            8'h05:   tk = c;
            8'h06:   tk = z;
            8'h07:   tk = n;
            8'h08:   tk = !z;
            8'h09:   tk = !n;
            8'h0A:   tk = !vf;
            default: tk = vf;
         endcase
         if (tk) begin
            off = int'(v.opnd[7:0]);
            if (off >= 128) off -= 256;
            tgt = (int'(v.pc) + off) & 'hFFFF;
            r.epc = tgt[15:0];
            r.eld = 1;
            r.lat = ((tgt >> 8) != (int'(v.pc) >> 8)) ? 4 : 3;
         end
      end else if (v.op == 8'h1C) begin
         if (!v.ind) begin
            r.epc = v.opnd;
            r.eld = 1;
         end else if (v.acks == 0) begin
            r.lat = 2 + TO; r.eerr = 1; r.chk_pc = 0;
         end else if (v.acks == 1) begin
            r.lat = 2 + (v.d + 1) + TO; r.eerr = 1; r.chk_pc = 0;
         end else begin
            ha = int'(hi_of(v.opnd));
            r.lat = 2 + 2 * (v.d + 1);
            r.epc = {mem[ha], mem[v.opnd]};
            r.eld = 1;
         end
      end else begin
         r.eerr = 1;
      end
      return r;
   endfunction

   task automatic run_op(input vec_t v, input string tag);
      int k;
      ack_delay  = v.d;
      ack_budget = v.acks;
      @(negedge clk);
      opcode = v.op; jmp_ind = v.ind;
      {flag_c, flag_z, flag_n, flag_v} = v.f;
      pc_in = v.pc; operand = v.opnd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      opcode = 8'($urandom); jmp_ind = 1'($urandom);
      pc_in = 16'($urandom); operand = 16'($urandom);
      {flag_c, flag_z, flag_n, flag_v} = 4'($urandom);
      k = 1;
      chk({tag, " busy"}, 32'(busy), 32'd1);
      while (!done && k < 64) begin
         @(negedge clk);
         k++;
      end
      chk({tag, " latency"}, 32'(k), 32'(v.lat));
      chk({tag, " pc_load"}, 32'(pc_load), 32'(v.eld));
      chk({tag, " err"}, 32'(err), 32'(v.eerr));
      if (v.chk_pc) chk({tag, " pc_out"}, 32'(pc_out), 32'(v.epc));
      @(negedge clk);
      chk({tag, " done_1cyc"}, 32'(done), 32'd0);
      chk({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   r, dcnt, k;
      logic [6:1] dseen;
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'h02FF] = 8'h34;
      mem[16'h0300] = 8'h12;
      mem[16'h0200] = 8'h56;
      mem_ack = 1'b0; mem_data = 8'h00;
      rst = 1'b1; start = 1'b0; opcode = 8'h00; jmp_ind = 1'b0;
      {flag_c, flag_z, flag_n, flag_v} = 4'h0;
      pc_in = 16'h0; operand = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst mem_addr", 32'(mem_addr), 32'd0);
      chk("rst pc_out", 32'(pc_out), 32'd0);
      chk("rst pc_load", 32'(pc_load), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      rst = 1'b0;

      // flags = {c,z,n,v}
      tbl[0]  = mk(8'h06, 0, 4'b0000, 16'h8010, 16'h0000, 0, 2,
                   2, 16'h8010, 0, 0, 1);
      tbl[1]  = mk(8'h08, 0, 4'b0000, 16'h8010, 16'h0005, 0, 2,
                   3, 16'h8015, 1, 0, 1);
      tbl[2]  = mk(8'h09, 0, 4'b0000, 16'h8002, 16'h00F0, 0, 2,
                   4, 16'h7FF2, 1, 0, 1);
`ifdef JMP_IND_PAGE_BUG_EN
      tbl[3]  = mk(8'h1C, 1, 4'b0000, 16'h1000, 16'h02FF, 0, 2,
                   4, 16'h5634, 1, 0, 1);
`else
      tbl[3]  = mk(8'h1C, 1, 4'b0000, 16'h1000, 16'h02FF, 0, 2,
                   4, 16'h1234, 1, 0, 1);
`endif
      tbl[4]  = mk(8'h1C, 1, 4'b0000, 16'h1000, 16'h02FF, 0, 0,
                   18, 16'h0000, 0, 1, 0);
      tbl[5]  = mk(8'h33, 0, 4'b1111, 16'h1234, 16'h0044, 0, 2,
                   2, 16'h1234, 0, 1, 1);
      tbl[6]  = mk(8'h1C, 0, 4'b0000, 16'h0100, 16'hBEEF, 0, 2,
                   2, 16'hBEEF, 1, 0, 1);
      tbl[7]  = mk(8'h05, 0, 4'b1000, 16'h10FE, 16'h0001, 0, 2,
                   3, 16'h10FF, 1, 0, 1);
      tbl[8]  = mk(8'h04, 0, 4'b1000, 16'h10FE, 16'h0001, 0, 2,
                   2, 16'h10FE, 0, 0, 1);
      tbl[9]  = mk(8'h0B, 0, 4'b0001, 16'h80F0, 16'h007F, 0, 2,
                   4, 16'h816F, 1, 0, 1);
      tbl[10] = mk(8'h07, 0, 4'b0010, 16'hFFF0, 16'h0020, 0, 2,
                   4, 16'h0010, 1, 0, 1);
      tbl[11] = mk(8'h0A, 0, 4'b0000, 16'h1280, 16'h0080, 0, 2,
                   3, 16'h1200, 1, 0, 1);
      tbl[12] = mk(8'h06, 1, 4'b0100, 16'h4000, 16'h0010, 0, 2,
                   3, 16'h4010, 1, 0, 1);
      tbl[13] = mk(8'h1C, 1, 4'b0000, 16'h1000, 16'h02FF, 2, 1,
                   21, 16'h0000, 0, 1, 0);
      tbl[14] = mk(8'h1C, 1, 4'b0000, 16'h1000, 16'h0300, 1, 2,
                   6, 16'h0012, 1, 0, 1);
      for (int i = 0; i < 15; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

      // start held high: ignored while busy, re-accepted after DONE
      ack_budget = 0;
      @(negedge clk);
      opcode = 8'h06; jmp_ind = 1'b0;
      {flag_c, flag_z, flag_n, flag_v} = 4'b0000;
      pc_in = 16'h2000; operand = 16'h0003; start = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         dseen[i] = done;
         if (i == 6) start = 1'b0;
      end
      chk("start_hold done pattern", 32'(dseen), 32'(6'b010010));
      repeat (3) @(negedge clk);
      chk("start_hold idle", 32'(busy), 32'd0);

      // reset while fetching the pointer high byte
      ack_delay = 0; ack_budget = 1;
      @(negedge clk);
      opcode = 8'h1C; jmp_ind = 1'b1;
      pc_in = 16'h3000; operand = 16'h2345; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(mem_req && mem_addr == hi_of(16'h2345)) && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("rst_mid reached IND_HI", 32'(k < 40), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid busy", 32'(busy), 32'd0);
      chk("rst_mid mem_req", 32'(mem_req), 32'd0);
      chk("rst_mid mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mid done", 32'(done), 32'd0);
      chk("rst_mid pc_out", 32'(pc_out), 32'd0);
      rst = 1'b0;
      dcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("rst_mid no done", 32'(dcnt), 32'd0);

      // random operations against the reference model
      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 11);
         if (r < 8) v.op = 8'(4 + r);
         else if (r < 10) v.op = 8'h1C;
         else begin
            v.op = 8'($urandom);
            while ((v.op >= 8'h04 && v.op <= 8'h0B) || v.op == 8'h1C)
               v.op = 8'($urandom);
         end
         v.ind  = 1'($urandom);
         v.f    = 4'($urandom);
         v.pc   = 16'($urandom);
         v.opnd = 16'($urandom);
         v.d    = $urandom_range(0, 3);
         r      = $urandom_range(0, 9);
         v.acks = (r == 0) ? 0 : (r == 1) ? 1 : 2;
         mem[v.opnd]        = 8'($urandom);
         mem[hi_of(v.opnd)] = 8'($urandom);
         v = model(v);
         run_op(v, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum mem_ack wait cycles per indirect fetch.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  begin resolution; sampled only in IDLE.
REQ-005 opcode  in  8  BCC=04, BCS=05, BEQ=06, BMI=07, BNE=08, BPL=09, BVC=0A, BVS=0B, JMP=1C (hex).
REQ-006 jmp_ind  in  1  JMP is indirect when high; ignored for branches.
REQ-007 flag_c, flag_z, flag_n, flag_v  in  1 each  status flags.
REQ-008 pc_in  in  16  address of the next sequential instruction.
REQ-009 operand  in  16  [7:0] signed offset for branches; full JMP target or pointer.
REQ-010 mem_req  out  1  read request for the indirect JMP pointer.
REQ-011 mem_addr  out  16  read address.
REQ-012 mem_ack  in  1  read data valid, single-cycle strobe.
REQ-013 mem_data  in  8  read data.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 pc_load  out  1  asserted with done when pc_out must be loaded.
REQ-017 pc_out  out  16  resolved PC; valid while done is high.
REQ-018 err  out  1  asserted with done on illegal opcode or timeout.

Function
REQ-019 States: IDLE, EVAL, ADD, FIX, IND_LO, IND_HI, DONE.
REQ-020 IDLE: start=1 latches opcode, jmp_ind, flags, pc_in and operand, then goes to EVAL; start outside IDLE is ignored.
REQ-021 EVAL, branch not taken: go to DONE with pc_out=pc_in and pc_load=0.
REQ-022 EVAL, branch taken: go to ADD.
REQ-023 ADD: target = pc_in + sign-extended operand[7:0], modulo 2^16.
REQ-024 ADD transition: goes to FIX if target[15:8] != pc_in[15:8], else to DONE.
REQ-025 FIX: one-cycle page-cross penalty, then DONE.
REQ-026 Latency from start cycle to done, as 6502 timing: not taken = 2; taken, same page = 3; taken, page cross = 4.
REQ-027 JMP absolute: EVAL goes to DONE with pc_out=operand and pc_load=1 (latency 2).
REQ-028 JMP indirect: EVAL goes to IND_LO.
REQ-029 IND_LO: mem_req=1, mem_addr=operand; on mem_ack, latch the low byte and go to IND_HI.
REQ-030 IND_HI: mem_req=1 with the high-byte address per REQ-040/041; on mem_ack, go to DONE with pc_out={hi,lo} and pc_load=1.
REQ-031 mem_req deasserts in the cycle after mem_ack; mem_ack outside IND_LO/IND_HI is ignored.
REQ-032 Wait counter: cleared on entry to IND_LO and IND_HI; increments each cycle without mem_ack.
REQ-033 Timeout: when the count reaches TIMEOUT_CYCLES, go to DONE with err=1 and pc_load=0.
REQ-034 Opcode not in REQ-005: EVAL goes to DONE with err=1, pc_load=0, pc_out=pc_in.
REQ-035 DONE: done=1 for exactly one cycle, then IDLE; a new start is accepted in the following cycle.
REQ-036 pc_load, err and done are 0 in all states except DONE.

Reset
REQ-037 On rst, from any state including mid-fetch, go to IDLE at the next edge.
REQ-038 Reset values: mem_req=0, mem_addr=0, busy=0, done=0, pc_load=0, pc_out=0, err=0; wait counter and latched inputs cleared.
REQ-039 No done pulse for an operation aborted by reset.

Configuration
REQ-040 JMP_IND_PAGE_BUG_EN defined: high-byte address = {operand[15:8], operand[7:0]+1 mod 256}, matching the NMOS 6502 page-wrap bug.
REQ-041 JMP_IND_PAGE_BUG_EN undefined: high-byte address = operand+1 mod 2^16.

Verification
REQ-042 BEQ, flag_z=0, pc_in=0x8010 -> done 2 cycles after start; pc_out=0x8010, pc_load=0.
REQ-043 BNE, flag_z=0, pc_in=0x8010, offset 0x05 -> done at cycle 3; pc_out=0x8015, pc_load=1.
REQ-044 BPL, flag_n=0, pc_in=0x8002, offset 0xF0 -> done at cycle 4; pc_out=0x7FF2, pc_load=1.
REQ-045 JMP indirect, operand=0x02FF, memory[0x02FF]=0x34, memory[0x0300]=0x12, memory[0x0200]=0x56 -> pc_out=0x1234 without the macro; 0x5634 with it.
REQ-046 JMP indirect with mem_ack held low -> done with err=1 and pc_load=0 after 16 wait cycles; opcode 0x33 -> done with err=1 at cycle 2.
REQ-047 rst asserted during IND_HI -> next cycle: IDLE, mem_req=0, no done pulse.
